// File: rtl/serial_frame_loader.sv
// Purpose: parallel-in, LSB-first serial-out frame loader with downstream clear pulse.
// Latency: accept at edge t -> ds_clr during cycle t..t+1, bit i during cycle t+1+i..t+2+i.
// Backpressure: in_ready high in IDLE and on the last bit of a frame, forced low by abort.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready  word handshake (accept = in_valid & in_ready)
//   abort           synchronous frame drop, wins over a same-cycle accept
//   ds_clr          one-cycle clear pulse for the downstream serial stage
//   sbit, sbit_valid, sbit_first, sbit_last   serial bit stream with framing strobes
//   busy            high while a frame is in CLEAR or SHIFT
module serial_frame_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             ds_clr,
  output logic             sbit,
  output logic             sbit_valid,
  output logic             sbit_first,
  output logic             sbit_last,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ds_clr_q, ds_clr_d;
  logic sbit_q, sbit_d;
  logic sbit_valid_q, sbit_valid_d;
  logic sbit_first_q, sbit_first_d;
  logic sbit_last_q, sbit_last_d;
  logic busy_q, busy_d;

  logic last_bit;
  logic accept;

  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_MAX);
  // The only combinational output: abort masks ready so an aborted cycle never accepts.
  assign in_ready = !abort && ((state_q == IDLE) || last_bit);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sr_d    = in_data;
            cnt_d   = '0;
            state_d = CLEAR;
          end
        end
        CLEAR: begin
          cnt_d   = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          sr_d = sr_q >> 1;
          if (last_bit) begin
            cnt_d = '0;
            if (accept) begin
              // Back-to-back: the next word loads while its predecessor's last bit is out.
              sr_d    = in_data;
              state_d = CLEAR;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          sr_d    = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state values so they line up with state_q.
  always_comb begin
    ds_clr_d     = (state_d == CLEAR);
    sbit_valid_d = (state_d == SHIFT);
    sbit_d       = (state_d == SHIFT) && sr_d[0];
    sbit_first_d = (state_d == SHIFT) && (cnt_d == '0);
    sbit_last_d  = (state_d == SHIFT) && (cnt_d == CNT_MAX);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      ds_clr_q     <= 1'b0;
      sbit_q       <= 1'b0;
      sbit_valid_q <= 1'b0;
      sbit_first_q <= 1'b0;
      sbit_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      ds_clr_q     <= ds_clr_d;
      sbit_q       <= sbit_d;
      sbit_valid_q <= sbit_valid_d;
      sbit_first_q <= sbit_first_d;
      sbit_last_q  <= sbit_last_d;
      busy_q       <= busy_d;
    end
  end

  assign ds_clr     = ds_clr_q;
  assign sbit       = sbit_q;
  assign sbit_valid = sbit_valid_q;
  assign sbit_first = sbit_first_q;
  assign sbit_last  = sbit_last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_loader.sv
// Purpose: directed check of serial_frame_loader (WIDTH=8) with vector table and corner sequences.
// Latency: outputs sampled 1 time unit after each rising edge, inputs held from the previous sample.
// Backpressure: in_ready is checked against the inputs held at the sample point.
module tb_serial_frame_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       abort = 1'b0;
  logic       in_ready, ds_clr, sbit, sbit_valid, sbit_first, sbit_last, busy;

  int total = 0;
  int bad = 0;
  int busy_cyc = 0;

  serial_frame_loader #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .abort      (abort),
    .ds_clr     (ds_clr),
    .sbit       (sbit),
    .sbit_valid (sbit_valid),
    .sbit_first (sbit_first),
    .sbit_last  (sbit_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst, vld, ab;
    logic [7:0] dat;
    logic       rdy, clr, sb, sv, sf, sl, bz;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, vld, ab, input logic [7:0] dat,
                     input logic rdy, clr, sb, sv, sf, sl, bz);
    vec_t v;
    v.rst = rst; v.vld = vld; v.ab = ab; v.dat = dat;
    v.rdy = rdy; v.clr = clr; v.sb = sb; v.sv = sv; v.sf = sf; v.sl = sl; v.bz = bz;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy === 1'b1) busy_cyc++;
  endtask

  task automatic chk_outs(input string tag, input logic rdy, clr, sb, sv, sf, sl, bz);
    chk({tag, ".in_ready"},   {31'd0, in_ready},   {31'd0, rdy});
    chk({tag, ".ds_clr"},     {31'd0, ds_clr},     {31'd0, clr});
    chk({tag, ".sbit"},       {31'd0, sbit},       {31'd0, sb});
    chk({tag, ".sbit_valid"}, {31'd0, sbit_valid}, {31'd0, sv});
    chk({tag, ".sbit_first"}, {31'd0, sbit_first}, {31'd0, sf});
    chk({tag, ".sbit_last"},  {31'd0, sbit_last},  {31'd0, sl});
    chk({tag, ".busy"},       {31'd0, busy},       {31'd0, bz});
  endtask

  // Serial two's-complement stage as used downstream: out = bit ^ (a 1 seen earlier).
  function automatic logic [7:0] cpl_model(input logic [7:0] s);
    logic       seen;
    logic [7:0] o;
    seen = 1'b0;
    o    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      o[i] = s[i] ^ seen;
      seen = seen | s[i];
    end
    return o;
  endfunction

  // Eight SHIFT cycles: checks strobes and ready, returns the captured word.
  task automatic get_bits(input string tag, output logic [7:0] cap);
    cap = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk({tag, ".sv"},  {31'd0, sbit_valid}, 32'd1);
      chk({tag, ".sf"},  {31'd0, sbit_first}, {31'd0, (i == 0)});
      chk({tag, ".sl"},  {31'd0, sbit_last},  {31'd0, (i == 7)});
      chk({tag, ".rdy"}, {31'd0, in_ready},   {31'd0, (i == 7)});
      chk({tag, ".clr"}, {31'd0, ds_clr},     32'd0);
      cap[i] = sbit;
    end
  endtask

  // Full single frame: accept, CLEAR, eight bits, back to IDLE.
  task automatic frame(input string tag, input logic [7:0] word, input logic [7:0] exp_cpl);
    logic [7:0] cap;
    in_valid = 1'b1;
    in_data  = word;
    tick();
    chk_outs({tag, ".clear"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    in_data  = ~word;
    get_bits(tag, cap);
    chk({tag, ".word"}, {24'd0, cap}, {24'd0, word});
    chk({tag, ".cpl"},  {24'd0, cpl_model(cap)}, {24'd0, exp_cpl});
    tick();
    chk_outs({tag, ".idle"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [7:0] bits_2c;
  logic [7:0] c1, c2;

  initial begin
    // Reset 2 cycles, then 10 idle cycles.
    add(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
    // Single frame 8'b0010_1100, bits LSB first 0,0,1,1,0,1,0,0; in_data scrambled while shifting.
    add(0, 1, 0, 8'h2C, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 8'hFF, 0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 8'hFF, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 8'hFF, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 8'hFF, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 8'hFF, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 8'hFF, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 8'hFF, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 8'hFF, 1, 0, 0, 1, 0, 1, 1);
    add(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
    // Abort with valid in IDLE: ready masked, no frame starts.
    add(0, 1, 1, 8'h55, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);

    bits_2c = 8'h00;
    for (int k = 0; k < vt.size(); k++) begin
      reset    = vt[k].rst;
      in_valid = vt[k].vld;
      abort    = vt[k].ab;
      in_data  = vt[k].dat;
      tick();
      chk_outs($sformatf("vec%0d", k), vt[k].rdy, vt[k].clr, vt[k].sb, vt[k].sv,
               vt[k].sf, vt[k].sl, vt[k].bz);
      if (k >= 13 && k <= 20) bits_2c[k-13] = sbit;
    end
    chk("vec.cpl_2c", {24'd0, cpl_model(bits_2c)}, 32'hD4);

    // Back-to-back 8'h01 then 8'h80 with in_valid held high.
    busy_cyc = 0;
    in_valid = 1'b1;
    in_data  = 8'h01;
    tick();
    chk("b2b.clr1", {31'd0, ds_clr}, 32'd1);
    in_data = 8'h80;
    get_bits("b2b.f1", c1);
    tick();
    chk("b2b.clr2", {31'd0, ds_clr}, 32'd1);
    chk("b2b.clr2_sv", {31'd0, sbit_valid}, 32'd0);
    in_valid = 1'b0;
    in_data  = 8'h00;
    get_bits("b2b.f2", c2);
    tick();
    chk("b2b.idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b.cycles", busy_cyc, 32'd18);
    chk("b2b.word1", {24'd0, c1}, 32'h01);
    chk("b2b.word2", {24'd0, c2}, 32'h80);
    chk("b2b.cpl1", {24'd0, cpl_model(c1)}, 32'hFF);
    chk("b2b.cpl2", {24'd0, cpl_model(c2)}, 32'h80);

    // Abort at cnt=3 of 8'hFF, then a clean frame of 8'h02.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    chk("abt.clr", {31'd0, ds_clr}, 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abt.bit", {31'd0, sbit}, 32'd1);
    end
    abort = 1'b1;
    #1;
    chk("abt.rdy_masked", {31'd0, in_ready}, 32'd0);
    tick();
    chk_outs("abt.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    #1;
    chk("abt.rdy_back", {31'd0, in_ready}, 32'd1);
    frame("abt.f02", 8'h02, 8'hFE);

    // Reset at cnt=5 of 8'h3C, then frame 8'hA5.
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("rst.mid_valid", {31'd0, sbit_valid}, 32'd1);
    reset = 1'b1;
    tick();
    chk_outs("rst.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_outs("rst.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame("rst.fA5", 8'hA5, 8'h5B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_loader.md
# serial_frame_loader

Parallel-in, serial-out frame loader that feeds the team's LSB-first serial bit-stream stages (e.g. the serial two's-complement FSM). It accepts a WIDTH-bit word over a valid/ready handshake. For each word it issues a one-cycle clear pulse that re-arms the downstream Mealy stage. It then shifts the word out LSB first, one bit per clock, with framing strobes.

## Interface
- WIDTH, 8: word width in bits, ≥2.
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high; clock clk.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a word this cycle.
- abort  input  1  synchronous frame abort; drops the current frame.
- ds_clr  output  1  one-cycle clear pulse to the downstream stage's reset.
- sbit  output  1  serial data bit, LSB first.
- sbit_valid  output  1  sbit carries a frame bit this cycle.
- sbit_first  output  1  marks bit 0 of the frame.
- sbit_last  output  1  marks bit WIDTH-1 of the frame.
- busy  output  1  a frame is in CLEAR or SHIFT.

## Operation
- State machine with states IDLE, CLEAR, SHIFT. All outputs are registered or decoded from registered state only; no input-to-output combinational path except in_ready.
- Accept occurs when in_valid and in_ready are both high at a clock edge. The loader then captures in_data into shift register sr and enters CLEAR.
- IDLE:
  - in_ready=1.
  - An accept moves the FSM to CLEAR; otherwise it stays in IDLE.
- CLEAR (exactly 1 cycle):
  - ds_clr=1, sbit_valid=0, sbit=0.
  - Moves to SHIFT with bit counter cnt=0.
- SHIFT (WIDTH cycles):
  - sbit=sr[0], sbit_valid=1.
  - sbit_first=(cnt==0), sbit_last=(cnt==WIDTH-1).
  - Each cycle sr shifts right by one with 0 filled in, and cnt increments.
  - in_ready=1 only when cnt==WIDTH-1.
  - At cnt==WIDTH-1: an accept loads sr and goes to CLEAR (back-to-back frames); with no accept, the FSM goes to IDLE.
- Counter width is clog2(WIDTH). cnt never exceeds WIDTH-1 and resets to 0 on every CLEAR entry.
- abort, when high in any state, forces IDLE next cycle and clears sr and cnt.
  - abort has priority over an accept in the same cycle: that word is not taken and in_ready is forced to 0 while abort=1.
  - No ds_clr is issued by abort itself; the next frame's CLEAR re-arms the downstream stage.
- busy=1 in CLEAR and SHIFT.
- Outside SHIFT, sbit=0 and sbit_valid/first/last=0.
- in_data is sampled only on accept; changes at other times have no effect.

## Timing
- Reset (synchronous) puts the FSM in IDLE with sr=0 and cnt=0. Outputs after the reset edge: in_ready=1, ds_clr=0, sbit=0, sbit_valid=0, sbit_first=0, sbit_last=0, busy=0.
- Reset asserted mid-frame truncates the frame at the next edge. No partial bits follow and no ds_clr is issued.
- Accept at edge t gives:
  - ds_clr=1 during cycle t..t+1.
  - Bit i on sbit during cycle t+1+i..t+2+i, for i=0..WIDTH-1.
- The downstream synchronous reset samples ds_clr at edge t+1, so the downstream stage starts in its initial state for bit 0.
- Throughput: one word per WIDTH+1 cycles with continuous in_valid. The only gap between frames is the CLEAR cycle.
- Latency from accept to first sbit_valid: 2 edges.

## Test plan
- Reset then idle: hold reset 2 cycles, in_valid=0 → in_ready=1, busy=0, ds_clr=0, sbit_valid=0 on every cycle for 10 cycles.
- Single frame, WIDTH=8, in_data=8'b0010_1100:
  - ds_clr=1 for exactly one cycle.
  - Then sbit=0,0,1,1,0,1,0,0 with sbit_first on the first bit and sbit_last on the eighth.
  - Then IDLE. Chained into the two's-complementer, the serial output is 1101_0100 LSB first.
- Back-to-back: in_valid held high with words 8'h01 then 8'h80:
  - in_ready pulses on the last bit of frame 1.
  - Frame 2's ds_clr follows immediately.
  - Total 18 cycles for both frames.
  - Complementer outputs are 8'hFF then 8'h80.
- Abort mid-frame: abort at cnt=3 of 8'hFF → IDLE next cycle, sbit_valid=0, busy=0. A new accept of 8'h02 produces a clean CLEAR plus 8-bit frame.
- Abort versus accept: abort=1 and in_valid=1 in the same cycle in IDLE → in_ready=0, no frame starts, state stays IDLE.
- Reset mid-frame: reset at cnt=5 → the next cycle has all outputs at reset values. The following frame, 8'hA5, serializes correctly.
